// File: rtl/cam_array_seq_if.sv
// Operation/response bundle between the parallel-processor controller (master)
// and the clocked CAM array (slave).
interface cam_array_seq_if #(
    parameter int WORDS = 100,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(WORDS + 1);

    logic                 op_valid;
    logic                 op_ready;
    logic [2:0]           op_code;
    logic [2*WIDTH-1:0]   mismatch_lines;
    logic [2*WIDTH-1:0]   write_lines;
    logic [AW-1:0]        ld_addr;
    logic [WIDTH-1:0]     ld_data;
    logic [WORDS-1:0]     match_lines;
    logic                 any_responder;
    logic [WIDTH-1:0]     read_lines;
    logic                 read_valid;
    logic [CW-1:0]        resp_count;
    logic                 count_done;

    modport master (
        output op_valid, op_code, mismatch_lines, write_lines, ld_addr, ld_data,
        input  op_ready, match_lines, any_responder, read_lines, read_valid,
               resp_count, count_done
    );

    modport slave (
        input  op_valid, op_code, mismatch_lines, write_lines, ld_addr, ld_data,
        output op_ready, match_lines, any_responder, read_lines, read_valid,
               resp_count, count_done
    );
endinterface

// File: rtl/cam_array_seq.sv
// Clocked associative array: WORDS stored words with a responder tag per word,
// single-cycle associative ops plus a serial responder count.
module cam_array_seq #(
    parameter int WORDS = 100,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    cam_array_seq_if.slave   bus
);
    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(WORDS + 1);

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_TAG_ALL    = 3'd1;
    localparam logic [2:0] OP_SEARCH     = 3'd2;
    localparam logic [2:0] OP_WRITE      = 3'd3;
    localparam logic [2:0] OP_READ_FIRST = 3'd4;
    localparam logic [2:0] OP_STEP       = 3'd5;
    localparam logic [2:0] OP_LOAD       = 3'd6;
    localparam logic [2:0] OP_COUNT      = 3'd7;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] store_q [WORDS];
    logic [WIDTH-1:0] store_d [WORDS];
    logic [WORDS-1:0] match_q, match_d;
    logic [WIDTH-1:0] read_q, read_d;
    logic             read_valid_q, read_valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             count_done_q, count_done_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [WORDS-1:0] snap_q, snap_d;
    logic [AW-1:0]    idx_q, idx_d;

    logic             accept;
    logic             is_write;
    logic             is_load;

    assign accept   = bus.op_valid && (state_q == ST_IDLE);
    assign is_write = accept && (bus.op_code == OP_WRITE);
    assign is_load  = accept && (bus.op_code == OP_LOAD);

    logic [WIDTH-1:0] mm_one, mm_zero, set_only, clr_only;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign mm_zero[gi]  = bus.mismatch_lines[2*gi];
        assign mm_one[gi]   = bus.mismatch_lines[2*gi+1];
        assign set_only[gi] = bus.write_lines[2*gi+1] & ~bus.write_lines[2*gi];
        assign clr_only[gi] = bus.write_lines[2*gi]   & ~bus.write_lines[2*gi+1];
    end

    logic [WORDS-1:0] mismatch;
    logic [WORDS-1:0] load_hit;

    // Out-of-range LOAD addresses simply match no word and are dropped.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
        assign mismatch[gi] = |((mm_one & store_q[gi]) | (mm_zero & ~store_q[gi]));
        assign load_hit[gi] = is_load && (bus.ld_addr == AW'(gi));
        assign store_d[gi]  = load_hit[gi]              ? bus.ld_data :
                              (is_write && match_q[gi]) ? ((store_q[gi] & ~clr_only) | set_only) :
                                                          store_q[gi];

        always_ff @(posedge clk) begin
            if (rst) begin
                store_q[gi] <= '0;
            end else begin
                store_q[gi] <= store_d[gi];
            end
        end
    end

    // Isolate the lowest set tag (two's-complement trick) and mux its word.
    logic [WORDS-1:0] first_oh;
    logic [WIDTH-1:0] first_data;

    assign first_oh = match_q & (~match_q + WORDS'(1));

    always_comb begin
        first_data = '0;
        for (int i = 0; i < WORDS; i++) begin
            first_data = first_data | ({WIDTH{first_oh[i]}} & store_q[i]);
        end
    end

    always_comb begin
        state_d      = state_q;
        match_d      = match_q;
        read_d       = read_q;
        read_valid_d = 1'b0;
        count_d      = count_q;
        count_done_d = 1'b0;
        acc_d        = acc_q;
        snap_d       = snap_q;
        idx_d        = idx_q;

        if (state_q == ST_IDLE) begin
            if (bus.op_valid) begin
                case (bus.op_code)
                    OP_NOP:        ;
                    OP_TAG_ALL:    match_d = '1;
                    OP_SEARCH:     match_d = match_q & ~mismatch;
                    OP_WRITE:      ;
                    OP_READ_FIRST: begin
                        read_d       = first_data;
                        read_valid_d = 1'b1;
                    end
                    OP_STEP:       match_d = match_q & ~first_oh;
                    OP_LOAD:       ;
                    OP_COUNT: begin
                        state_d = ST_COUNT;
                        snap_d  = match_q;
                        idx_d   = '0;
                        acc_d   = '0;
                    end
                endcase
            end
        end else begin
            // The snapshot shifts down so bit 0 is always the word being scanned.
            acc_d  = acc_q + CW'(snap_q[0]);
            snap_d = snap_q >> 1;
            idx_d  = idx_q + AW'(1);
            if (idx_q == AW'(WORDS - 1)) begin
                count_d      = acc_d;
                count_done_d = 1'b1;
                state_d      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            match_q      <= '0;
            read_q       <= '0;
            read_valid_q <= 1'b0;
            count_q      <= '0;
            count_done_q <= 1'b0;
            acc_q        <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            match_q      <= match_d;
            read_q       <= read_d;
            read_valid_q <= read_valid_d;
            count_q      <= count_d;
            count_done_q <= count_done_d;
            acc_q        <= acc_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
        end
    end

    assign bus.op_ready      = (state_q == ST_IDLE);
    assign bus.match_lines   = match_q;
    assign bus.any_responder = |match_q;
    assign bus.read_lines    = read_q;
    assign bus.read_valid    = read_valid_q;
    assign bus.resp_count    = count_q;
    assign bus.count_done    = count_done_q;
endmodule

// File: tb/tb_cam_array_seq.sv
// Bench for cam_array_seq: directed scenarios plus random ops against an
// array/loop reference model; reads and counts are scored by a monitor.
module tb_cam_array_seq;
    localparam int WORDS = 100;
    localparam int WIDTH = 32;
    localparam int AW    = $clog2(WORDS);

    localparam logic [2:0] NOP = 3'd0, TAG_ALL = 3'd1, SEARCH = 3'd2, WRITE = 3'd3;
    localparam logic [2:0] READ_FIRST = 3'd4, STEP = 3'd5, LOAD = 3'd6, COUNT = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_array_seq_if #(.WORDS(WORDS), .WIDTH(WIDTH)) bus ();
    cam_array_seq #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_read_q [$];
    int               exp_count_q [$];

    logic [WIDTH-1:0] m_store [WORDS];
    logic [WORDS-1:0] m_tag;
    int               m_last_count;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic word_mismatches(input logic [WIDTH-1:0] s, input logic [2*WIDTH-1:0] mm);
        for (int j = 0; j < WIDTH; j++) begin
            if (mm[2*j+1] && s[j]) return 1'b1;
            if (mm[2*j] && !s[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [WIDTH-1:0] apply_write(input logic [WIDTH-1:0] s, input logic [2*WIDTH-1:0] wl);
        logic [WIDTH-1:0] r = s;
        for (int j = 0; j < WIDTH; j++) begin
            if (wl[2*j+1] && !wl[2*j]) r[j] = 1'b1;
            if (wl[2*j] && !wl[2*j+1]) r[j] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [2*WIDTH-1:0] exact_mm(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] mm;
        for (int j = 0; j < WIDTH; j++) begin
            mm[2*j]   = v[j];
            mm[2*j+1] = ~v[j];
        end
        return mm;
    endfunction

    task automatic model_op(input logic [2:0] code, input logic [2*WIDTH-1:0] mm,
                            input logic [2*WIDTH-1:0] wl, input logic [AW-1:0] addr,
                            input logic [WIDTH-1:0] data);
        int cnt;
        int first;
        case (code)
            TAG_ALL: m_tag = '1;
            SEARCH: begin
                for (int i = 0; i < WORDS; i++)
                    if (word_mismatches(m_store[i], mm)) m_tag[i] = 1'b0;
            end
            WRITE: begin
                for (int i = 0; i < WORDS; i++)
                    if (m_tag[i]) m_store[i] = apply_write(m_store[i], wl);
            end
            READ_FIRST: begin
                first = -1;
                for (int i = WORDS - 1; i >= 0; i--) if (m_tag[i]) first = i;
                exp_read_q.push_back(first < 0 ? '0 : m_store[first]);
            end
            STEP: begin
                first = -1;
                for (int i = WORDS - 1; i >= 0; i--) if (m_tag[i]) first = i;
                if (first >= 0) m_tag[first] = 1'b0;
            end
            LOAD: if (int'(addr) < WORDS) m_store[addr] = data;
            COUNT: begin
                cnt = 0;
                for (int i = 0; i < WORDS; i++) cnt += int'(m_tag[i]);
                exp_count_q.push_back(cnt);
                m_last_count = cnt;
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] code, input logic [2*WIDTH-1:0] mm,
                         input logic [2*WIDTH-1:0] wl, input logic [AW-1:0] addr,
                         input logic [WIDTH-1:0] data);
        int guard = 0;
        while (bus.op_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (bus.op_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL op_ready_timeout: actual=%0b required=1", bus.op_ready);
        end else begin
            bus.op_valid       = 1'b1;
            bus.op_code        = code;
            bus.mismatch_lines = mm;
            bus.write_lines    = wl;
            bus.ld_addr        = addr;
            bus.ld_data        = data;
            model_op(code, mm, wl, addr, data);
            $display("op code=%0d mm=%0h wl=%0h addr=%0d data=%0h", code, mm, wl, addr, data);
            @(posedge clk);
            @(negedge clk);
            bus.op_valid = 1'b0;
            check("match_lines", 128'(bus.match_lines), 128'(m_tag));
            check("any_responder", 128'(bus.any_responder), 128'(m_tag != '0));
        end
    endtask

    task automatic op_simple(input logic [2:0] code);
        issue(code, '0, '0, '0, '0);
    endtask

    task automatic dump_store();
        op_simple(TAG_ALL);
        for (int i = 0; i < WORDS; i++) begin
            op_simple(READ_FIRST);
            op_simple(STEP);
        end
    endtask

    task automatic count_check();
        int edges;
        int prev = m_last_count;
        op_simple(COUNT);
        edges = 1;
        check("count_op_ready_low", 128'(bus.op_ready), 128'(0));
        while (bus.count_done !== 1'b1 && edges < 3 * WORDS) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 50) check("resp_count_hold", 128'(bus.resp_count), 128'(prev));
        end
        check("count_latency", 128'(edges), 128'(WORDS + 1));
    endtask

    always @(negedge clk) begin
        if (bus.read_valid === 1'b1) begin
            if (exp_read_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL read_unexpected: actual=%0h required=no pulse", bus.read_lines);
            end else begin
                $display("read lines=%0h", bus.read_lines);
                check("read_lines", 128'(bus.read_lines), 128'(exp_read_q.pop_front()));
            end
        end
        if (bus.count_done === 1'b1) begin
            if (exp_count_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL count_unexpected: actual=%0d required=no pulse", bus.resp_count);
            end else begin
                $display("count resp=%0d", bus.resp_count);
                check("resp_count", 128'(bus.resp_count), 128'(exp_count_q.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*WIDTH-1:0] mm, wl;
        logic [WORDS-1:0]   exp_tags;
        int                 r, prev, stray;

        bus.op_valid = 1'b0; bus.op_code = NOP; bus.mismatch_lines = '0;
        bus.write_lines = '0; bus.ld_addr = '0; bus.ld_data = '0;
        for (int i = 0; i < WORDS; i++) m_store[i] = '0;
        m_tag = '0;
        m_last_count = 0;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_match", 128'(bus.match_lines), 128'(0));
        check("rst_op_ready", 128'(bus.op_ready), 128'(1));
        check("rst_read_lines", 128'(bus.read_lines), 128'(0));
        check("rst_resp_count", 128'(bus.resp_count), 128'(0));
        check("rst_pulses", 128'({bus.read_valid, bus.count_done}), 128'(0));

        // Load pattern, exact search for 457, count
        for (int i = 0; i < WORDS; i++) begin
            logic [WIDTH-1:0] v;
            case (i)
                0: v = 456; 1: v = 457; 2: v = 1000; 3: v = 1000; 4: v = 457;
                WORDS - 1: v = 457;
                default: v = WIDTH'(i);
            endcase
            issue(LOAD, '0, '0, AW'(i), v);
        end
        op_simple(TAG_ALL);
        issue(SEARCH, exact_mm(457), '0, '0, '0);
        exp_tags = '0;
        exp_tags[1] = 1'b1; exp_tags[4] = 1'b1; exp_tags[WORDS-1] = 1'b1;
        check("search457_tags", 128'(bus.match_lines), 128'(exp_tags));
        count_check();

        // First-responder read and stepping
        op_simple(READ_FIRST);
        op_simple(STEP); op_simple(STEP); op_simple(STEP);
        check("step_empty", 128'(bus.any_responder), 128'(0));
        op_simple(READ_FIRST);

        // Odd words: clear bit 0
        op_simple(TAG_ALL);
        mm = '0; mm[0] = 1'b1;
        issue(SEARCH, mm, '0, '0, '0);
        wl = '0; wl[0] = 1'b1;
        issue(WRITE, '0, wl, '0, '0);
        dump_store();

        // Bit 3 both lines (unchanged), set bit 31
        op_simple(TAG_ALL);
        issue(SEARCH, exact_mm(1000), '0, '0, '0);
        wl = '0; wl[6] = 1'b1; wl[7] = 1'b1; wl[2*WIDTH-1] = 1'b1;
        issue(WRITE, '0, wl, '0, '0);
        op_simple(READ_FIRST);

        // Random ops
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            mm = '0; wl = '0;
            for (int k = 0; k < 2 * WIDTH; k++) begin
                mm[k] = ($urandom_range(0, 15) == 0);
                wl[k] = ($urandom_range(0, 7) == 0);
            end
            if (r < 10)      op_simple(TAG_ALL);
            else if (r < 30) issue(SEARCH, mm, '0, '0, '0);
            else if (r < 42) issue(WRITE, '0, wl, '0, '0);
            else if (r < 55) op_simple(READ_FIRST);
            else if (r < 65) op_simple(STEP);
            else if (r < 90) issue(LOAD, '0, '0, AW'($urandom_range(0, (1 << AW) - 1)),
                                   ($urandom_range(0, 1) == 1) ? WIDTH'($urandom_range(0, 15)) : WIDTH'($urandom));
            else if (r < 94) count_check();
            else             op_simple(NOP);
        end
        dump_store();

        // COUNT aborted by reset; ops offered during the scan are ignored
        op_simple(TAG_ALL);
        op_simple(STEP);
        prev = m_last_count;
        op_simple(COUNT);
        for (int c = 1; c < 40; c++) begin
            if (c >= 5 && c <= 10) begin
                bus.op_valid = 1'b1;
                bus.op_code  = (c < 8) ? TAG_ALL : STEP;
            end else begin
                bus.op_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (c == 20) begin
                check("scan_op_ready", 128'(bus.op_ready), 128'(0));
                check("scan_resp_hold", 128'(bus.resp_count), 128'(prev));
                check("scan_tags_kept", 128'(bus.match_lines), 128'(m_tag));
            end
        end
        bus.op_valid = 1'b0;
        exp_count_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WORDS; i++) m_store[i] = '0;
        m_tag = '0;
        m_last_count = 0;
        check("abort_op_ready", 128'(bus.op_ready), 128'(1));
        check("abort_resp_count", 128'(bus.resp_count), 128'(0));
        check("abort_match", 128'(bus.match_lines), 128'(0));
        stray = 0;
        for (int c = 0; c < WORDS + 20; c++) begin
            @(negedge clk);
            if (bus.count_done === 1'b1) stray++;
        end
        check("abort_no_count_done", 128'(stray), 128'(0));

        // Still functional after the abort
        issue(LOAD, '0, '0, AW'(7), 32'hCAFE_0457);
        op_simple(TAG_ALL);
        issue(SEARCH, exact_mm(32'hCAFE_0457), '0, '0, '0);
        op_simple(READ_FIRST);
        count_check();
        repeat (3) @(negedge clk);
        check("read_queue_drained", 128'(exp_read_q.size()), 128'(0));
        check("count_queue_drained", 128'(exp_count_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
